// File: rtl/pc_branch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_branch_sequencer
//
// Owns the fetch PC register and sequences the ID-stage jump/branch unit.
// Control-transfer instructions sitting in ID are decoded here. If a branch
// or jr reads an rs1 that is still being produced by EX or MEM, IF/ID is held
// and a bubble goes into ID/EX until the operand can be forwarded. Once the
// operand is usable, the jump unit's takeBranch/target is accepted. Fetch is
// then redirected and the wrong-path instruction in IF/ID is flushed. The r31
// link write for jal is also generated here.
//
// Optional feature macro: BRANCH_STATS_EN
//   When defined, two saturating counters and their ports are added:
//   stat_taken (redirect cycles) and stat_stall (hazard hold cycles).
//
// Ports
//   clk            in   1   clock, all state updates on rising edge
//   rst            in   1   synchronous active-high reset
//   stall_in       in   1   external freeze, holds all state
//   id_instruction in   32  instruction in ID
//   id_pc          in   32  PC of the ID instruction
//   branch_taken   in   1   takeBranch from the jump/branch unit
//   branch_target  in   32  redirect target from the jump/branch unit
//   ex_rd          in   5   EX destination register
//   ex_regwrite    in   1   EX instruction writes ex_rd
//   ex_is_load     in   1   EX instruction is a load
//   mem_rd         in   5   MEM destination register
//   mem_is_load    in   1   MEM instruction is a load writing mem_rd
//   fetch_pc       out  32  registered fetch address
//   ifid_hold      out  1   hold IF/ID (hazard wait or stall_in)
//   ifid_flush     out  1   replace IF/ID with a NOP on the next edge
//   idex_bubble    out  1   insert a NOP into ID/EX (hazard wait)
//   link_we        out  1   write r31 this cycle (jal)
//   link_data      out  32  id_pc + PC_STEP
//   stat_taken     out  32  (BRANCH_STATS_EN only) redirect cycle count
//   stat_stall     out  32  (BRANCH_STATS_EN only) hazard hold cycle count
// -----------------------------------------------------------------------------
module pc_branch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4,
    parameter int unsigned LOAD_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic [31:0] id_instruction,
    input  logic [31:0] id_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_rd,
    input  logic        mem_is_load,
    output logic [31:0] fetch_pc,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        link_we,
    output logic [31:0] link_data
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stall
`endif
);

    localparam logic [31:0] STEP         = 32'(PC_STEP);
    // Extra hold cycles after the first one when rs1 comes from a load in EX.
    localparam logic [1:0]  LOAD_WAIT_M1 = 2'(LOAD_WAIT - 1);

    // Control-transfer opcodes, one per decode lane: j, jal, beqz, bnez, jr.
    localparam logic [29:0] CTRL_OPCODES = {6'h12, 6'h05, 6'h04, 6'h03, 6'h02};
    // Lanes whose instruction reads rs1 (beqz, bnez, jr).
    localparam logic [4:0]  RS1_USERS    = 5'b11100;
    localparam int          JAL_LANE     = 1;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t      state_reg;
    logic [1:0]  wait_cnt_reg;
    logic [31:0] fetch_pc_reg;

    // ---------------------------------------------------------------- decode
    logic [5:0] opcode;
    logic [4:0] rs1;
    logic [4:0] op_match;
    logic       uses_rs1;
    logic       is_jal;
    logic       unused_bits;

    assign opcode      = id_instruction[31:26];
    assign rs1         = id_instruction[25:21];
    assign unused_bits = ^id_instruction[20:0];

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_decode
            assign op_match[gi] = (opcode == CTRL_OPCODES[gi*6 +: 6]);
        end
    endgenerate

    assign uses_rs1 = |(op_match & RS1_USERS);
    assign is_jal   = op_match[JAL_LANE];

    // ---------------------------------------------------------------- hazard
    logic       hz_ex;
    logic       hz_mem;
    logic       hazard;
    logic [1:0] hz_wait_m1;

    assign hz_ex      = ex_regwrite && (ex_rd == rs1);
    assign hz_mem     = mem_is_load && (mem_rd == rs1);
    // r0 is hard-wired, so it never creates a dependency.
    assign hazard     = uses_rs1 && (rs1 != 5'd0) && (hz_ex || hz_mem);
    // EX match takes precedence: a load there needs the longer wait even if
    // MEM also matches.
    assign hz_wait_m1 = (hz_ex && ex_is_load) ? LOAD_WAIT_M1 : 2'd0;

    // ------------------------------------------------------- cycle decisions
    logic running;
    logic hazard_hold;
    logic redirect;

    assign running     = (state_reg == ST_RUN);
    // A WAIT cycle always holds; in RUN a fresh hazard holds in the same cycle.
    assign hazard_hold = !stall_in && (!running || hazard);
    assign redirect    = !stall_in && running && !hazard && branch_taken;

    assign fetch_pc    = fetch_pc_reg;
    assign ifid_hold   = !rst && (stall_in || hazard_hold);
    assign idex_bubble = !rst && hazard_hold;
    assign ifid_flush  = !rst && redirect;
    // jal has no rs1, but it is gated by the same "not holding" condition so a
    // held jal can never write the link register twice.
    assign link_we     = !rst && !stall_in && running && !hazard && is_jal;
    assign link_data   = id_pc + STEP;

    // ------------------------------------------------------------ sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            state_reg    <= ST_RUN;
            wait_cnt_reg <= 2'd0;
        end else if (!stall_in) begin
            if (state_reg == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg - 2'd1;
                // Back to RUN after the last hold; the hazard is re-evaluated
                // against the pipeline state seen in that next cycle.
                if (wait_cnt_reg <= 2'd1) begin
                    state_reg <= ST_RUN;
                end
            end else if (hazard) begin
                wait_cnt_reg <= hz_wait_m1;
                if (hz_wait_m1 != 2'd0) begin
                    state_reg <= ST_WAIT;
                end
            end else if (branch_taken) begin
                fetch_pc_reg <= branch_target;
            end else begin
                fetch_pc_reg <= fetch_pc_reg + STEP;
            end
        end
    end

    // ------------------------------------------------------------ statistics
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken_reg;
    logic [31:0] stat_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_taken_reg <= 32'd0;
            stat_stall_reg <= 32'd0;
        end else begin
            if (redirect && (stat_taken_reg != 32'hFFFF_FFFF)) begin
                stat_taken_reg <= stat_taken_reg + 32'd1;
            end
            if (hazard_hold && (stat_stall_reg != 32'hFFFF_FFFF)) begin
                stat_stall_reg <= stat_stall_reg + 32'd1;
            end
        end
    end

    assign stat_taken = stat_taken_reg;
    assign stat_stall = stat_stall_reg;
`else
    // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_sequencer
//
// Directed bench for pc_branch_sequencer. A behavioural model tracks the
// expected fetch PC and the number of forced hold cycles still owed. A compare
// process checks every DUT output against that model on each falling edge. The
// directed scenarios also pin key values with hand-computed literals.
// Define BRANCH_STATS_EN for both files to exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_pc_branch_sequencer;

    localparam int LOAD_STALL = 2;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_is_load;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic [31:0] fetch_pc;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        link_we;
    logic [31:0] link_data;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_stall;
`endif

    pc_branch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_is_load     (ex_is_load),
        .mem_rd         (mem_rd),
        .mem_is_load    (mem_is_load),
        .fetch_pc       (fetch_pc),
        .ifid_hold      (ifid_hold),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .link_we        (link_we),
        .link_data      (link_data)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken     (stat_taken),
        .stat_stall     (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Number of hold cycles the ID instruction needs, straight from the rules.
    function automatic int stall_cycles_needed(input logic [31:0] instr,
                                               input logic [4:0] e_rd, input logic e_we,
                                               input logic e_ld, input logic [4:0] m_rd,
                                               input logic m_ld);
        logic [5:0] op;
        logic [4:0] src;
        bit         reads;
        op    = instr[31:26];
        src   = instr[25:21];
        reads = (op == 6'h04) || (op == 6'h05) || (op == 6'h12);
        if (!reads || src == 5'd0) return 0;
        if (e_we && e_rd == src) return e_ld ? LOAD_STALL : 1;
        if (m_ld && m_rd == src) return 1;
        return 0;
    endfunction

    // ------------------------------------------------------------ model
    logic [31:0] m_pc;
    int          m_hold_rem = 0;
    int          m_taken    = 0;
    int          m_stall    = 0;

    always @(posedge clk) begin
        int need;
        need = stall_cycles_needed(id_instruction, ex_rd, ex_regwrite, ex_is_load,
                                   mem_rd, mem_is_load);
        if (rst) begin
            m_pc       = 32'h0000_0000;
            m_hold_rem = 0;
            m_taken    = 0;
            m_stall    = 0;
        end else if (!stall_in) begin
            if (m_hold_rem > 0) begin
                m_hold_rem = m_hold_rem - 1;
                m_stall    = m_stall + 1;
            end else if (need > 0) begin
                m_hold_rem = need - 1;
                m_stall    = m_stall + 1;
            end else if (branch_taken) begin
                m_pc    = branch_target;
                m_taken = m_taken + 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // ------------------------------------------------------------ compare
    always @(negedge clk) begin
        int          need;
        logic        e_hold;
        logic        e_bub;
        logic        e_flush;
        logic        e_link;
        logic [31:0] instr;
        instr   = id_instruction;
        need    = stall_cycles_needed(id_instruction, ex_rd, ex_regwrite, ex_is_load,
                                      mem_rd, mem_is_load);
        e_hold  = 1'b0;
        e_bub   = 1'b0;
        e_flush = 1'b0;
        e_link  = 1'b0;
        if (!rst) begin
            if (stall_in) begin
                e_hold = 1'b1;
            end else if (m_hold_rem > 0 || need > 0) begin
                e_hold = 1'b1;
                e_bub  = 1'b1;
            end else begin
                e_flush = branch_taken;
                e_link  = (instr[31:26] == 6'h03);
            end
        end
        chk("model fetch_pc",    fetch_pc,           m_pc);
        chk("model ifid_hold",   {31'd0, ifid_hold},   {31'd0, e_hold});
        chk("model idex_bubble", {31'd0, idex_bubble}, {31'd0, e_bub});
        chk("model ifid_flush",  {31'd0, ifid_flush},  {31'd0, e_flush});
        chk("model link_we",     {31'd0, link_we},     {31'd0, e_link});
        chk("model link_data",   link_data,          id_pc + 32'd4);
`ifdef BRANCH_STATS_EN
        chk("model stat_taken",  stat_taken,         32'(m_taken));
        chk("model stat_stall",  stat_stall,         32'(m_stall));
`endif
    end

    // ------------------------------------------------------------ helpers
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        id_instruction = 32'h0000_0000;
        branch_taken   = 1'b0;
        ex_rd          = 5'd0;
        ex_regwrite    = 1'b0;
        ex_is_load     = 1'b0;
        mem_rd         = 5'd0;
        mem_is_load    = 1'b0;
    endtask

    task automatic lit_flags(input string tag, input logic hold, input logic bub,
                             input logic flush, input logic [31:0] pc);
        chk({tag, " hold"},   {31'd0, ifid_hold},   {31'd0, hold});
        chk({tag, " bubble"}, {31'd0, idex_bubble}, {31'd0, bub});
        chk({tag, " flush"},  {31'd0, ifid_flush},  {31'd0, flush});
        chk({tag, " pc"},     fetch_pc,             pc);
    endtask

    // beqz r3 with the producer a load in EX: two holds, then redirect.
    task automatic beqz_load(input logic [31:0] start_pc, input logic [31:0] tgt);
        id_instruction = {6'h04, 5'd3, 21'd0};
        id_pc          = start_pc;
        ex_rd          = 5'd3;
        ex_regwrite    = 1'b1;
        ex_is_load     = 1'b1;
        branch_taken   = 1'b1;
        branch_target  = tgt;
        @(negedge clk); lit_flags("beqz hold1", 1'b1, 1'b1, 1'b0, start_pc);
        next_cycle();
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
        @(negedge clk); lit_flags("beqz hold2", 1'b1, 1'b1, 1'b0, start_pc);
        next_cycle();
        @(negedge clk); lit_flags("beqz redirect", 1'b0, 1'b0, 1'b1, start_pc);
        next_cycle();
        nop();
        @(negedge clk); lit_flags("beqz target", 1'b0, 1'b0, 1'b0, tgt);
        next_cycle();
        $display("beqz r3 load-in-EX at pc 0x%08h -> target 0x%08h", start_pc, tgt);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst = 1'b1; stall_in = 1'b0; id_pc = 32'h0; branch_target = 32'h0;
        nop();

        // 1: reset, then sequential fetch
        repeat (2) next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit_flags("seq", 1'b0, 1'b0, 1'b0, 32'(i * 4));
            chk("seq link_we", {31'd0, link_we}, 32'd0);
            next_cycle();
        end
        $display("reset + sequential fetch 0,4,8,C");

        // 2: load-use branch hazard
        beqz_load(32'h0000_0010, 32'h0000_0400);

        // 3: jal behind three stall_in cycles
        id_instruction = {6'h03, 26'h0};
        id_pc = 32'h0000_0100; branch_taken = 1'b1; branch_target = 32'h0000_0200;
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit_flags("jal stall", 1'b1, 1'b0, 1'b0, 32'h0000_0404);
            chk("jal stall link_we", {31'd0, link_we}, 32'd0);
            next_cycle();
        end
        stall_in = 1'b0;
        @(negedge clk);
        chk("jal link_we", {31'd0, link_we}, 32'd1);
        chk("jal link_data", link_data, 32'h0000_0104);
        lit_flags("jal redirect", 1'b0, 1'b0, 1'b1, 32'h0000_0404);
        next_cycle();
        nop();
        @(negedge clk);
        chk("jal after link_we", {31'd0, link_we}, 32'd0);
        chk("jal target pc", fetch_pc, 32'h0000_0200);
        next_cycle();
        $display("jal id_pc 0x100 -> link 0x104, target 0x200 after stall release");

        // 4: jr r0 never hazards; bnez r7 vs load in MEM holds one cycle
        id_instruction = {6'h12, 5'd0, 21'd0};
        ex_rd = 5'd0; ex_regwrite = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0300;
        @(negedge clk); lit_flags("jr r0", 1'b0, 1'b0, 1'b1, 32'h0000_0204);
        next_cycle();
        nop();
        id_instruction = {6'h05, 5'd7, 21'd0};
        mem_rd = 5'd7; mem_is_load = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0500;
        @(negedge clk); lit_flags("bnez hold", 1'b1, 1'b1, 1'b0, 32'h0000_0300);
        next_cycle();
        mem_rd = 5'd0; mem_is_load = 1'b0;
        @(negedge clk); lit_flags("bnez redirect", 1'b0, 1'b0, 1'b1, 32'h0000_0300);
        next_cycle();
        nop();
        @(negedge clk); lit_flags("bnez target", 1'b0, 1'b0, 1'b0, 32'h0000_0500);
        next_cycle();
        $display("jr r0 no stall; bnez r7 load-in-MEM one hold");

        // 5a: PC wrap
        id_instruction = {6'h12, 5'd0, 21'd0};
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        next_cycle();
        nop();
        @(negedge clk); chk("wrap top", fetch_pc, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge clk); chk("wrap zero", fetch_pc, 32'h0000_0000);
        next_cycle();
        $display("fetch_pc 0xFFFFFFFC wraps to 0x0");

        // 5b: stall_in during a hazard wait freezes the wait counter
        id_instruction = {6'h04, 5'd3, 21'd0};
        ex_rd = 5'd3; ex_regwrite = 1'b1; ex_is_load = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h0000_0700;
        @(negedge clk); lit_flags("wait hold1", 1'b1, 1'b1, 1'b0, 32'h0000_0004);
        next_cycle();
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
        stall_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); lit_flags("wait frozen", 1'b1, 1'b0, 1'b0, 32'h0000_0004);
            next_cycle();
        end
        stall_in = 1'b0;
        @(negedge clk); lit_flags("wait hold2", 1'b1, 1'b1, 1'b0, 32'h0000_0004);
        next_cycle();
        @(negedge clk); lit_flags("wait redirect", 1'b0, 1'b0, 1'b1, 32'h0000_0004);
        next_cycle();
        nop();
        @(negedge clk); chk("wait target", fetch_pc, 32'h0000_0700);
        next_cycle();
        $display("stall_in inside hazard wait keeps the remaining hold");

        // 5c: reset while waiting
        id_instruction = {6'h04, 5'd3, 21'd0};
        ex_rd = 5'd3; ex_regwrite = 1'b1; ex_is_load = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h0000_0600;
        @(negedge clk); lit_flags("rstwait hold", 1'b1, 1'b1, 1'b0, 32'h0000_0704);
        next_cycle();
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
        rst = 1'b1;
        @(negedge clk); lit_flags("rstwait in reset", 1'b0, 1'b0, 1'b0, 32'h0000_0704);
        next_cycle();
        rst = 1'b0;
        nop();
        @(negedge clk); lit_flags("rstwait run0", 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        next_cycle();
        @(negedge clk); lit_flags("rstwait run1", 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        next_cycle();
        $display("reset during hazard wait returns to RESET_PC and RUN");

        // 6: two load-use branches from a clean reset
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        beqz_load(32'h0000_0000, 32'h0000_0040);
        beqz_load(32'h0000_0044, 32'h0000_0080);
`ifdef BRANCH_STATS_EN
        @(negedge clk);
        chk("stat_taken", stat_taken, 32'd2);
        chk("stat_stall", stat_stall, 32'd4);
        $display("statistics after two load-use branches: taken %0d stall %0d",
                 stat_taken, stat_stall);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
